// File: rtl/his_acq_scheduler_pkg.sv
// rtl/his_acq_scheduler_pkg.sv - shared state encoding and derived-width helpers for the histogram scheduler
package his_acq_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACQ   = 3'd2,
    S_DRAIN = 3'd3,
    S_PEAK  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Index width for a counter that runs 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pixel index width.
  function automatic int pix_w(input int pixel_num);
    return idx_w(pixel_num);
  endfunction

  // Clear address spans every bin of every pixel sharing the BRAM.
  function automatic int clr_w(input int pixel_num, input int nb);
    return idx_w(pixel_num) + nb;
  endfunction

  // Laser-cycle counter width.
  function automatic int acq_w(input int acq_num);
    return idx_w(acq_num);
  endfunction

endpackage

// File: rtl/his_sched_counter.sv
// rtl/his_sched_counter.sv - cascaded input/pixel/acquisition counter with last-sample flag
module his_sched_counter
  import his_acq_scheduler_pkg::*;
#(
  parameter int DATA_NUM  = 4,
  parameter int PIXEL_NUM = 4,
  parameter int ACQ_NUM   = 33333
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          step,
  output logic [pix_w(PIXEL_NUM)-1:0]   pixel_cnt,
  output logic                          last
);

  localparam int DW = idx_w(DATA_NUM);
  localparam int PW = pix_w(PIXEL_NUM);
  localparam int AW = acq_w(ACQ_NUM);

  logic [DW-1:0] input_cnt;
  logic [AW-1:0] acq_cnt;
  logic          input_wrap;
  logic          pixel_wrap;
  logic          acq_wrap;

  assign input_wrap = (input_cnt == DW'(DATA_NUM - 1));
  assign pixel_wrap = (pixel_cnt == PW'(PIXEL_NUM - 1));
  assign acq_wrap   = (acq_cnt == AW'(ACQ_NUM - 1));
  assign last       = input_wrap && pixel_wrap && acq_wrap;

  // Each accepted sample advances the innermost counter; wraps carry outward and all three return to 0 after the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_cnt <= '0;
      pixel_cnt <= '0;
      acq_cnt   <= '0;
    end else if (clear) begin
      input_cnt <= '0;
      pixel_cnt <= '0;
      acq_cnt   <= '0;
    end else if (step) begin
      if (input_wrap) begin
        input_cnt <= '0;
        if (pixel_wrap) begin
          pixel_cnt <= '0;
          acq_cnt   <= acq_wrap ? '0 : acq_cnt + AW'(1);
        end else begin
          pixel_cnt <= pixel_cnt + PW'(1);
        end
      end else begin
        input_cnt <= input_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/his_acq_scheduler.sv
// rtl/his_acq_scheduler.sv - two-pass dToF frame sequencer; HIS_SCHED_DROP_CNT_EN enables the dropped-sample counter
module his_acq_scheduler
  import his_acq_scheduler_pkg::*;
#(
  parameter int NP        = 16,
  parameter int NB        = 8,
  parameter int PIXEL_NUM = 4,
  parameter int DATA_NUM  = 4,
  parameter int ACQ_NUM   = 33333,
  parameter int PIPE_LAT  = 2
) (
  input  logic                              clk,
  input  logic                              res,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              tdc_valid,
  input  logic [NP-1:0]                     tdc_data,
  output logic                              tdc_ready,
  output logic                              his_wr_en,
  output logic [NP-1:0]                     his_data,
  output logic [pix_w(PIXEL_NUM)-1:0]       his_pixel,
  output logic                              his_pass,
  output logic                              clr_en,
  output logic [clr_w(PIXEL_NUM, NB)-1:0]   clr_addr,
  output logic                              peak_req,
  input  logic                              peak_ack,
  output logic                              frame_done,
  output logic                              busy,
  output logic [15:0]                       drop_cnt
);

  localparam int PW       = pix_w(PIXEL_NUM);
  localparam int CW       = clr_w(PIXEL_NUM, NB);
  localparam int DRW      = idx_w(PIPE_LAT);
  localparam int CLR_LAST = PIXEL_NUM * (2 ** NB) - 1;

  state_t          state, state_nx;
  logic            pass_nx;
  logic [CW-1:0]   clr_cnt, clr_nx;
  logic [DRW-1:0]  drain_cnt, drain_nx;
  logic [PW-1:0]   pixel_cnt;
  logic            last;
  logic            acq_hs;
  logic            start_ok;
  logic            abort_ok;

  // Handshake is decoded from the state register so it never loops through the ready output.
  assign acq_hs   = tdc_valid && (state == S_ACQ);
  assign start_ok = (state == S_IDLE) && start && !abort;
  assign abort_ok = abort && (state != S_IDLE);
  assign clr_addr = clr_cnt;

  his_sched_counter #(
    .DATA_NUM  (DATA_NUM),
    .PIXEL_NUM (PIXEL_NUM),
    .ACQ_NUM   (ACQ_NUM)
  ) u_counter (
    .clk       (clk),
    .rst       (res),
    .clear     (abort_ok || start_ok),
    .step      (acq_hs),
    .pixel_cnt (pixel_cnt),
    .last      (last)
  );

  // State, pass select and phase counters.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= S_IDLE;
      his_pass  <= 1'b0;
      clr_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      his_pass  <= pass_nx;
      clr_cnt   <= clr_nx;
      drain_cnt <= drain_nx;
    end
  end

  // Next-state decode and state-derived strobes; abort overrides every transition.
  always_comb begin
    state_nx   = state;
    pass_nx    = his_pass;
    clr_nx     = clr_cnt;
    drain_nx   = drain_cnt;
    tdc_ready  = 1'b0;
    clr_en     = 1'b0;
    peak_req   = 1'b0;
    frame_done = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_CLEAR;
          pass_nx  = 1'b0;
          clr_nx   = '0;
        end
      end
      S_CLEAR: begin
        clr_en = 1'b1;
        if (clr_cnt == CW'(CLR_LAST)) begin
          clr_nx   = '0;
          state_nx = S_ACQ;
        end else begin
          clr_nx = clr_cnt + CW'(1);
        end
      end
      S_ACQ: begin
        tdc_ready = 1'b1;
        if (acq_hs && last) begin
          state_nx = S_DRAIN;
          drain_nx = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRW'(PIPE_LAT - 1)) begin
          drain_nx = '0;
          state_nx = S_PEAK;
        end else begin
          drain_nx = drain_cnt + DRW'(1);
        end
      end
      S_PEAK: begin
        peak_req = 1'b1;
        if (peak_ack) begin
          if (!his_pass) begin
            pass_nx  = 1'b1;
            clr_nx   = '0;
            state_nx = S_CLEAR;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        pass_nx    = 1'b0;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort_ok) begin
      state_nx = S_IDLE;
      pass_nx  = 1'b0;
      clr_nx   = '0;
      drain_nx = '0;
    end
  end

  // One-cycle write pipeline: an accepted sample appears on the histogram port the next cycle, even across an abort.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      his_wr_en <= 1'b0;
      his_data  <= '0;
      his_pixel <= '0;
    end else begin
      his_wr_en <= acq_hs;
      if (acq_hs) begin
        his_data  <= tdc_data;
        his_pixel <= pixel_cnt;
      end
    end
  end

`ifdef HIS_SCHED_DROP_CNT_EN
  // Count cycles where the source offers data while the frame is busy but not accepting; saturates.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      drop_cnt <= 16'd0;
    end else if (start_ok) begin
      drop_cnt <= 16'd0;
    end else if (tdc_valid && !tdc_ready && busy && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_his_acq_scheduler.sv
// tb/tb_his_acq_scheduler.sv - randomized self-checking bench with a phase-level reference model
module tb_his_acq_scheduler;

  localparam int NP        = 16;
  localparam int NB        = 3;
  localparam int PIXEL_NUM = 2;
  localparam int DATA_NUM  = 2;
  localparam int ACQ_NUM   = 3;
  localparam int PIPE_LAT  = 2;
  localparam int CLR_N     = PIXEL_NUM * (2 ** NB);
  localparam int TOTAL     = PIXEL_NUM * DATA_NUM * ACQ_NUM;
  localparam int LIM       = 2000;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tdc_valid = 1'b0;
  logic [NP-1:0] tdc_data = '0;
  logic          tdc_ready;
  logic          his_wr_en;
  logic [NP-1:0] his_data;
  logic [0:0]    his_pixel;
  logic          his_pass;
  logic          clr_en;
  logic [3:0]    clr_addr;
  logic          peak_req;
  logic          peak_ack;
  logic          frame_done;
  logic          busy;
  logic [15:0]   drop_cnt;

  logic ack_auto = 1'b0;
  logic stray_ack = 1'b0;
  assign peak_ack = ack_auto | stray_ack;

  his_acq_scheduler #(
    .NP(NP), .NB(NB), .PIXEL_NUM(PIXEL_NUM), .DATA_NUM(DATA_NUM),
    .ACQ_NUM(ACQ_NUM), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .res(res), .start(start), .abort(abort),
    .tdc_valid(tdc_valid), .tdc_data(tdc_data), .tdc_ready(tdc_ready),
    .his_wr_en(his_wr_en), .his_data(his_data), .his_pixel(his_pixel),
    .his_pass(his_pass), .clr_en(clr_en), .clr_addr(clr_addr),
    .peak_req(peak_req), .peak_ack(peak_ack), .frame_done(frame_done),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle,1 clear,2 acquire,3 drain,4 peak,5 done.
  int   m_phase = 0, m_k = 0, m_acc = 0, m_pass = 0, m_pix = 0, m_drop = 0;
  bit   m_wr = 0, m_hs = 0;
  logic [NP-1:0] m_data = '0;

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_phase = 0; m_k = 0; m_acc = 0; m_pass = 0; m_pix = 0;
      m_drop = 0; m_wr = 0; m_data = '0;
    end else begin
      m_hs = tdc_valid && (m_phase == 2);
      if (m_phase == 0 && start && !abort) m_drop = 0;
      else if (tdc_valid && m_phase != 0 && m_phase != 2 && m_drop < 65535) m_drop++;
      m_wr = m_hs;
      if (m_hs) begin
        m_data = tdc_data;
        m_pix  = (m_acc / DATA_NUM) % PIXEL_NUM;
      end
      if (abort && m_phase != 0) begin
        m_phase = 0; m_pass = 0; m_k = 0; m_acc = 0;
      end else begin
        case (m_phase)
          0: if (start && !abort) begin m_phase = 1; m_k = 0; m_pass = 0; m_acc = 0; end
          1: if (m_k == CLR_N - 1) begin m_phase = 2; m_k = 0; end else m_k++;
          2: if (m_hs) begin
               m_acc++;
               if (m_acc == TOTAL) begin m_phase = 3; m_k = 0; m_acc = 0; end
             end
          3: if (m_k == PIPE_LAT - 1) begin m_phase = 4; m_k = 0; end else m_k++;
          4: if (peak_ack) begin
               if (m_pass == 0) begin m_pass = 1; m_phase = 1; m_k = 0; end
               else m_phase = 5;
             end
          default: begin m_pass = 0; m_phase = 0; end
        endcase
      end
    end
  end

  // Observation counters used by the literal per-frame checks.
  int clr_cycles = 0, done_cnt = 0, wr_idx = 0, pix_bad = 0;
  int wr_pass [2] = '{0, 0};
  int pat [4] = '{0, 0, 1, 1};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int exp_drop;
`ifdef HIS_SCHED_DROP_CNT_EN
    exp_drop = m_drop;
`else
    exp_drop = 0;
`endif
    chk("busy", busy, m_phase != 0);
    chk("tdc_ready", tdc_ready, m_phase == 2);
    chk("clr_en", clr_en, m_phase == 1);
    if (m_phase == 1) chk("clr_addr", clr_addr, m_k);
    chk("peak_req", peak_req, m_phase == 4);
    chk("frame_done", frame_done, m_phase == 5);
    chk("his_pass", his_pass, m_pass);
    chk("his_wr_en", his_wr_en, m_wr);
    if (m_wr) begin
      chk("his_data", his_data, m_data);
      chk("his_pixel", his_pixel, m_pix);
    end
    chk("drop_cnt", drop_cnt, exp_drop);
    if (clr_en) clr_cycles++;
    if (frame_done) done_cnt++;
    if (his_wr_en) begin
      wr_pass[his_pass]++;
      if (int'(his_pixel) != pat[wr_idx % 4]) pix_bad++;
      wr_idx++;
    end
  end

  // Peak finder stand-in: acknowledges after peak_req has been seen for 5 cycles.
  bit ack_en = 1;
  int pk_cnt = 0;
  always @(negedge clk) begin
    if (peak_req && ack_en) begin
      pk_cnt++;
      ack_auto = (pk_cnt >= 5);
    end else begin
      pk_cnt = 0;
      ack_auto = 1'b0;
    end
  end

  // Source: 0 idle, 1 always valid, 2 toggling, 3 random.
  int vmode = 0;
  bit tgl = 1;
  always @(posedge clk) begin
    #1;
    case (vmode)
      1: tdc_valid = 1'b1;
      2: begin tdc_valid = tgl; tgl = !tgl; end
      3: tdc_valid = 1'($urandom_range(0, 1));
      default: tdc_valid = 1'b0;
    endcase
    tdc_data = NP'($urandom);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic obs_clear();
    clr_cycles = 0; done_cnt = 0; wr_idx = 0; pix_bad = 0;
    wr_pass[0] = 0; wr_pass[1] = 0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int pass_req, input int acc_req, input string nm);
    int n = 0;
    while (!(m_phase == ph && (pass_req < 0 || m_pass == pass_req) &&
             (acc_req < 0 || m_acc == acc_req)) && n < LIM) begin
      cyc(1); n++;
    end
    chk(nm, n < LIM, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < LIM) begin cyc(1); n++; end
    chk(nm, n < LIM, 1);
  endtask

  task automatic run_frame(input int vm, input bit poke_start);
    obs_clear();
    vmode = vm;
    do_start();
    if (poke_start) begin cyc(3); do_start(); end
    wait_idle("frame_timeout");
    vmode = 0;
    cyc(2);
    chk("clear_cycles", clr_cycles, 2 * CLR_N);
    chk("coarse_writes", wr_pass[0], 12);
    chk("fine_writes", wr_pass[1], 12);
    chk("done_pulses", done_cnt, 1);
    chk("pixel_pattern", pix_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tdc_ready, 0);
    chk("rst_pass", his_pass, 0);
    chk("rst_clr_en", clr_en, 0);
    chk("rst_drop", drop_cnt, 0);
    #2 res = 1'b0;
    cyc(2);

    // Full frame with a continuously valid source, then toggling, then random.
    run_frame(1, 1'b0);
    run_frame(2, 1'b1);
    run_frame(3, 1'b0);

    // Simultaneous start and abort in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; cyc(1); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);

    // Abort on the 5th accepted sample of the fine pass.
    obs_clear();
    vmode = 1;
    do_start();
    wait_phase(2, 1, 4, "reach_fine_5th");
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", tdc_ready, 0);
    chk("abort_pass", his_pass, 0);
    chk("abort_last_write", his_wr_en, 1);
    vmode = 0;
    cyc(2);
    run_frame(1, 1'b0);

    // Asynchronous reset while waiting in the fine-pass peak handshake.
    obs_clear();
    vmode = 3;
    do_start();
    wait_phase(1, 1, -1, "reach_fine_clear");
    ack_en = 0;
    wait_phase(4, 1, -1, "reach_fine_peak");
    vmode = 0;
    cyc(3);
    chk("pre_res_pass", his_pass, 1);
    #2 res = 1'b1;
    #1;
    chk("res_busy", busy, 0);
    chk("res_peak_req", peak_req, 0);
    chk("res_pass", his_pass, 0);
    chk("res_clr_en", clr_en, 0);
    chk("res_wr_en", his_wr_en, 0);
    chk("res_data", his_data, 0);
    @(posedge clk); #1 res = 1'b0;
    ack_en = 1;
    cyc(3);
    chk("res_no_done", done_cnt, 0);

    // Stray peak_ack in IDLE has no effect.
    stray_ack = 1'b1; cyc(3); stray_ack = 1'b0;
    chk("stray_ack_idle", busy, 0);
    cyc(2);

`ifdef HIS_SCHED_DROP_CNT_EN
    vmode = 1;
    cyc(1);
    do_start();
    wait_phase(2, 0, 0, "drop_reach_acq");
    chk("drop_after_clear", drop_cnt, 16);
    abort = 1'b1; cyc(1); abort = 1'b0;
    vmode = 0;
    cyc(2);
    do_start();
    chk("drop_cleared_on_start", drop_cnt, 0);
    abort = 1'b1; cyc(1); abort = 1'b0;
    cyc(2);
`else
    vmode = 3;
    do_start();
    wait_phase(2, 0, -1, "drop_reach_acq");
    chk("drop_tied_zero", drop_cnt, 0);
    abort = 1'b1; cyc(1); abort = 1'b0;
    vmode = 0;
    cyc(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/his_acq_scheduler.md
Name: his_acq_scheduler

Overview:
- Sequences one dToF frame through the shared per-RAM histogram datapath.
- A frame is two passes: a coarse pass (pass 0), then a fine pass (pass 1). Each pass runs: clear BRAM → accumulate timestamps → drain → peak handshake.
- Sits between the TDC/timestamp source and the histogram builder. It owns the pixel/input/acquisition counters and the pass select, and issues clear, write and peak-capture commands.

Parameters:
- NP, 16, timestamp width in bits
- NB, 8, bin-address width; bins per histogram = 2**NB
- PIXEL_NUM, 4, pixels sharing one BRAM
- DATA_NUM, 4, timestamps per pixel per laser cycle
- ACQ_NUM, 33333, laser cycles per pass
- PIPE_LAT, 2, histogram write-pipeline depth drained before a peak request

Ports:
- clk, input, 1, clock
- res, input, 1, asynchronous active-high reset
- start, input, 1, frame start pulse; ignored unless IDLE
- abort, input, 1, synchronous abort to IDLE
- tdc_valid, input, 1, timestamp valid
- tdc_data, input, NP, timestamp
- tdc_ready, output, 1, timestamp accepted when valid&&ready
- his_wr_en, output, 1, histogram write strobe
- his_data, output, NP, registered timestamp
- his_pixel, output, clog2(PIXEL_NUM), pixel index of his_data
- his_pass, output, 1, 0 = coarse, 1 = fine
- clr_en, output, 1, BRAM clear strobe
- clr_addr, output, clog2(PIXEL_NUM)+NB, clear address
- peak_req, output, 1, request peak capture for current pass
- peak_ack, input, 1, peak finder done
- frame_done, output, 1, one-cycle pulse at frame end
- busy, output, 1, high whenever not IDLE
- drop_cnt, output, 16, dropped-sample counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; his_pass 0.
- State IDLE:
  - start → CLEAR; his_pass←0.
- State CLEAR:
  - clr_en=1 for exactly PIXEL_NUM·2**NB cycles.
  - clr_addr runs 0..PIXEL_NUM·2**NB−1, then → ACQ.
- State ACQ:
  - tdc_ready = (state==ACQ), combinational from the state register.
  - Each handshake registers his_data, his_pixel=pixel_cnt and his_wr_en=1 on the next cycle (latency 1).
  - his_wr_en is 0 on all other cycles.
  - Counter nesting: input_cnt wraps at DATA_NUM−1 and increments pixel_cnt; pixel_cnt wraps at PIXEL_NUM−1 and increments acq_cnt.
  - Handshake with all three counters at max: counters clear, state → DRAIN. tdc_ready is low from the next cycle.
  - tdc_valid while not ready is back-pressure, never data loss at the source.
- State DRAIN:
  - Waits PIPE_LAT cycles, then → PEAK.
- State PEAK:
  - peak_req held high until peak_ack is sampled high; peak_req drops on the following cycle.
  - If pass 0: his_pass←1, → CLEAR.
  - If pass 1: → DONE.
  - peak_ack outside PEAK is ignored.
- State DONE:
  - frame_done=1 for one cycle, his_pass←0, → IDLE.
- abort in any non-IDLE state, next cycle:
  - → IDLE; counters, his_pass, clr_en, peak_req all 0.
  - A write already registered still completes (his_wr_en may be high that cycle).
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- start while busy: ignored.
- res mid-frame: immediate return to reset values; no frame_done.
- busy = (state != IDLE).

Optional Feature:
- Macro HIS_SCHED_DROP_CNT_EN.
- Defined:
  - drop_cnt increments on each cycle with tdc_valid && !tdc_ready && busy.
  - Saturates at 16'hFFFF.
  - Cleared on res and on an accepted start.
- Undefined: drop_cnt tied to 0, no counter logic.

Decomposition:
- Shared package (parametersSiFH.vh style) holds:
  - state encodings IDLE/CLEAR/ACQ/DRAIN/PEAK/DONE
  - derived widths: pixel index width, clear-address width, acq_cnt width = clog2(ACQ_NUM)
- One sub-module, his_sched_counter: the cascaded input/pixel/acq counter with wrap flags and a last-sample flag.

Test Plan:
- Bench parameters: PIXEL_NUM=2, DATA_NUM=2, ACQ_NUM=3, NB=3, PIPE_LAT=2.
- Clear sweep: start → clr_en high exactly 16 cycles, clr_addr 0..15, then tdc_ready=1.
- Full frame, tdc_valid always 1:
  - Coarse pass: 12 his_wr_en pulses, his_pixel pattern 0,0,1,1 repeated, his_pass=0.
  - Then 2 drain cycles, then peak_req. Ack after 5 cycles → second clear of 16 cycles.
  - Fine pass: 12 writes with his_pass=1, then peak, then one frame_done pulse, busy→0.
- Back-pressure: tdc_valid toggled 1,0,1,0 → his_data matches accepted samples in order; still 12 writes per pass.
- Abort at the 5th accepted sample: next cycle busy=0, tdc_ready=0, his_pass=0. A new start reruns from the clear sweep.
- Async res asserted mid-PEAK: all outputs 0 immediately, no frame_done. Stray peak_ack in IDLE: no effect.
- With HIS_SCHED_DROP_CNT_EN defined: tdc_valid held 1 during a 16-cycle clear → drop_cnt=16; next start resets it to 0.
